// File: rtl/bec_pkg.sv
// Shared definitions for the (29,16) burst-6 codeword path: code geometry,
// codeword type and the receive deframer state encoding.
package bec_pkg;

    localparam int N_CW    = 29;
    localparam int K_MSG   = 16;
    localparam int R_PAR   = 13;
    localparam int BURST_B = 6;

    // Index 0 is the first bit on the wire and the first message bit.
    typedef logic [0:N_CW-1] cw_t;

    typedef enum logic [0:0] {
        HUNT    = 1'b0,
        COLLECT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/bec_cw_fifo.sv
// Small synchronous codeword FIFO with a registered head entry and
// wrap-bit pointers; a push into a full FIFO succeeds only alongside a pop.
module bec_cw_fifo #(
    parameter int W     = 29,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [0:W-1] push_data,
    input  logic         pop,
    output logic [0:W-1] head_data,
    output logic         head_valid,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] PTR_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0] PTR_ONE  = {{(PW-1){1'b0}}, 1'b1};

    logic [0:W-1]  mem_q [DEPTH];
    logic [0:W-1]  mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] wr_ptr_d;
    logic [PW-1:0] rd_ptr_q;
    logic [PW-1:0] rd_ptr_d;
    logic [0:W-1]  head_q;
    logic [0:W-1]  head_d;
    logic          valid_q;
    logic          valid_d;
    logic          full_s;
    logic          empty_s;
    logic          do_pop_s;
    logic          do_push_s;

    assign full_s    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_s   = (wr_ptr_q == rd_ptr_q);
    assign do_pop_s  = pop && !empty_s;
    // When full, the slot being popped is the slot being written.
    assign do_push_s = push && (!full_s || do_pop_s);

    // Next storage, pointers and head entry.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_s) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        valid_d = (wr_ptr_d != rd_ptr_d);
        head_d  = mem_d[rd_ptr_d[AW-1:0]];
    end

    // FIFO state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
            wr_ptr_q <= PTR_ZERO;
            rd_ptr_q <= PTR_ZERO;
            head_q   <= {W{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    assign head_data  = head_q;
    assign head_valid = valid_q;
    assign full       = full_s;
    assign empty      = empty_s;

endmodule

// File: rtl/bec_rx_deframer.sv
// Serial-to-codeword deframer feeding the burst decoder: hunts for a start
// bit, assembles N bits, and queues completed codewords with overflow tracking.
module bec_rx_deframer
    import bec_pkg::*;
#(
    parameter int N     = N_CW,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ser_valid,
    input  logic         ser_bit,
    input  logic         ser_sof,
    output logic [0:N-1] cw_data,
    output logic         cw_valid,
    input  logic         cw_ready,
    input  logic         ovf_clr,
    output logic         frame_err,
    output logic         ovf_sticky
);

    localparam int CNT_W = $clog2(N);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    rx_state_e      state_q;
    rx_state_e      state_d;
    logic [CNT_W-1:0] bit_cnt_q;
    logic [CNT_W-1:0] bit_cnt_d;
    logic [0:N-1]   shift_q;
    logic [0:N-1]   shift_d;
    logic           frame_err_q;
    logic           frame_err_d;
    logic           ovf_q;
    logic           ovf_d;
    logic           push_s;
    logic           pop_s;
    logic           overflow_s;
    logic           fifo_full_s;
    logic           fifo_empty_s;
    logic           fifo_valid_s;
    logic [0:N-1]   fifo_head_s;

    assign pop_s      = cw_ready && !fifo_empty_s;
    assign overflow_s = push_s && fifo_full_s && !pop_s;

    // Framing FSM next-state, bit placement and sticky overflow update.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push_s      = 1'b0;
        case (state_q)
            HUNT: begin
                if (ser_valid && ser_sof) begin
                    shift_d   = {ser_bit, {(N-1){1'b0}}};
                    bit_cnt_d = CNT_ONE;
                    state_d   = COLLECT;
                end else begin
                    state_d = HUNT;
                end
            end
            COLLECT: begin
                if (ser_valid && ser_sof) begin
                    // Early start bit: drop the partial frame and resync here.
                    frame_err_d = 1'b1;
                    shift_d     = {ser_bit, {(N-1){1'b0}}};
                    bit_cnt_d   = CNT_ONE;
                    state_d     = COLLECT;
                end else if (ser_valid) begin
                    shift_d[bit_cnt_q] = ser_bit;
                    if (bit_cnt_q == CNT_LAST) begin
                        push_s    = 1'b1;
                        bit_cnt_d = CNT_ZERO;
                        state_d   = HUNT;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_ONE;
                        state_d   = COLLECT;
                    end
                end else begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d   = HUNT;
                bit_cnt_d = CNT_ZERO;
            end
        endcase

        if (overflow_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    // Deframer state and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= HUNT;
            bit_cnt_q   <= CNT_ZERO;
            shift_q     <= {N{1'b0}};
            frame_err_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            ovf_q       <= ovf_d;
        end
    end

    bec_cw_fifo #(
        .W     (N),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push_s),
        .push_data  (shift_d),
        .pop        (pop_s),
        .head_data  (fifo_head_s),
        .head_valid (fifo_valid_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s)
    );

    assign cw_data    = fifo_head_s;
    assign cw_valid   = fifo_valid_s;
    assign frame_err  = frame_err_q;
    assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_bec_rx_deframer.sv
// Randomized bench for bec_rx_deframer against a queue-based frame/FIFO model,
// plus directed scenarios with literal expectations.
module tb_bec_rx_deframer;

    localparam int N     = 29;
    localparam int DEPTH = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         ser_valid = 1'b0;
    logic         ser_bit = 1'b0;
    logic         ser_sof = 1'b0;
    logic         cw_ready = 1'b0;
    logic         ovf_clr = 1'b0;
    logic [0:N-1] cw_data;
    logic         cw_valid;
    logic         frame_err;
    logic         ovf_sticky;

    int checks = 0;
    int errors = 0;
    int ferr_seen = 0;
    logic [N-1:0] dq[$];

    always #5 clk = ~clk;

    bec_rx_deframer #(.N(N), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .ser_valid  (ser_valid),
        .ser_bit    (ser_bit),
        .ser_sof    (ser_sof),
        .cw_data    (cw_data),
        .cw_valid   (cw_valid),
        .cw_ready   (cw_ready),
        .ovf_clr    (ovf_clr),
        .frame_err  (frame_err),
        .ovf_sticky (ovf_sticky)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame accumulator plus a bounded queue of codewords.
    logic [N-1:0] m_q[$];
    bit           m_in;
    int           m_cnt;
    logic [N-1:0] m_acc;
    bit           m_ovf;
    bit           m_ferr;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_in = 0; m_cnt = 0; m_acc = '0; m_ovf = 0; m_ferr = 0;
        end else begin
            bit pop, push, ovr;
            logic [N-1:0] pd;
            pop = (m_q.size() > 0) && cw_ready;
            push = 0; pd = '0; m_ferr = 0;
            if (ser_valid) begin
                if (ser_sof) begin
                    if (m_in) m_ferr = 1;
                    m_in = 1; m_cnt = 1;
                    m_acc = {{(N-1){1'b0}}, ser_bit};
                end else if (m_in) begin
                    m_acc = (m_acc << 1) | {{(N-1){1'b0}}, ser_bit};
                    m_cnt++;
                    if (m_cnt == N) begin push = 1; pd = m_acc; m_in = 0; end
                end
            end
            ovr = push && (m_q.size() == DEPTH) && !pop;
            if (pop) void'(m_q.pop_front());
            if (push && !ovr) m_q.push_back(pd);
            if (ovr) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
        end
    end

    // Per-cycle comparison against the model; also records delivered codewords.
    always @(negedge clk) begin
        if (!rst) begin
            chk("cw_valid", {31'b0, cw_valid}, {31'b0, m_q.size() > 0});
            chk("frame_err", {31'b0, frame_err}, {31'b0, m_ferr});
            chk("ovf_sticky", {31'b0, ovf_sticky}, {31'b0, m_ovf});
            if (m_q.size() > 0) chk("cw_data", {3'b0, cw_data}, {3'b0, m_q[0]});
            if (frame_err) ferr_seen++;
            if (cw_valid && cw_ready) dq.push_back(cw_data);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        ser_valid = 1'b0; ser_sof = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_bits(input logic [N-1:0] v, input int nbits, input bit gaps, input bit rdy_last);
        for (int i = 0; i < nbits; i++) begin
            if (gaps) begin
                ser_valid = 1'b0; ser_sof = 1'b0;
                repeat ($urandom_range(0, 3)) tick();
            end
            ser_valid = 1'b1;
            ser_bit   = v[N-1-i];
            ser_sof   = (i == 0);
            if (rdy_last && i == N-1) cw_ready = 1'b1;
            tick();
            if (rdy_last && i == N-1) cw_ready = 1'b0;
        end
        ser_valid = 1'b0; ser_sof = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N-1:0] A, B, C, v;
        int f0;
        A = 29'h1FFFE7D7; B = 29'h00000000; C = 29'h15555555;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_cw_valid", {31'b0, cw_valid}, 32'd0);
        chk("rst_cw_data", {3'b0, cw_data}, 32'd0);
        chk("rst_frame_err", {31'b0, frame_err}, 32'd0);
        chk("rst_ovf", {31'b0, ovf_sticky}, 32'd0);
        rst = 1'b0;
        idle(2);

        // Clean frame: valid exactly one cycle after the last bit.
        cw_ready = 1'b1;
        send_bits(A, N, 0, 0);
        chk("clean_valid", {31'b0, cw_valid}, 32'd1);
        chk("clean_data", {3'b0, cw_data}, 32'h1FFFE7D7);
        chk("clean_ferr", {31'b0, frame_err}, 32'd0);
        tick();
        chk("clean_valid_drop", {31'b0, cw_valid}, 32'd0);
        idle(2);

        // Mid-frame resync.
        dq.delete(); f0 = ferr_seen;
        send_bits(C, 10, 0, 0);
        send_bits(B, N, 0, 0);
        idle(3);
        chk("resync_ferr_pulses", ferr_seen - f0, 32'd1);
        chk("resync_count", dq.size(), 32'd1);
        if (dq.size() > 0) chk("resync_data", {3'b0, dq[0]}, 32'd0);

        // Backpressure and overflow.
        cw_ready = 1'b0; dq.delete();
        send_bits(A, N, 0, 0);
        send_bits(B, N, 0, 0);
        send_bits(C, N, 0, 0);
        chk("ovf_set", {31'b0, ovf_sticky}, 32'd1);
        chk("ovf_head", {3'b0, cw_data}, 32'h1FFFE7D7);
        cw_ready = 1'b1;
        idle(3);
        chk("ovf_count", dq.size(), 32'd2);
        if (dq.size() == 2) begin
            chk("ovf_first", {3'b0, dq[0]}, 32'h1FFFE7D7);
            chk("ovf_second", {3'b0, dq[1]}, 32'h00000000);
        end
        chk("ovf_drained", {31'b0, cw_valid}, 32'd0);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        chk("ovf_cleared", {31'b0, ovf_sticky}, 32'd0);

        // Full FIFO with a pop on the completing cycle.
        cw_ready = 1'b0; dq.delete();
        send_bits(A, N, 0, 0);
        send_bits(B, N, 0, 0);
        send_bits(C, N, 0, 1);
        chk("fullpop_ovf", {31'b0, ovf_sticky}, 32'd0);
        chk("fullpop_head", {3'b0, cw_data}, 32'h00000000);
        cw_ready = 1'b1;
        idle(4);
        chk("fullpop_count", dq.size(), 32'd3);
        if (dq.size() == 3) begin
            chk("fullpop_a", {3'b0, dq[0]}, 32'h1FFFE7D7);
            chk("fullpop_b", {3'b0, dq[1]}, 32'h00000000);
            chk("fullpop_c", {3'b0, dq[2]}, 32'h15555555);
        end

        // Stray bits in HUNT, then a frame with idle gaps.
        dq.delete();
        for (int i = 0; i < 6; i++) begin
            ser_valid = 1'b1; ser_sof = 1'b0; ser_bit = 1'($urandom_range(0, 1));
            tick();
        end
        idle(1);
        chk("stray_no_valid", {31'b0, cw_valid}, 32'd0);
        v = N'($urandom);
        send_bits(v, N, 1, 0);
        idle(3);
        chk("gaps_count", dq.size(), 32'd1);
        if (dq.size() > 0) chk("gaps_data", {3'b0, dq[0]}, {3'b0, v});

        // Randomized traffic checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            ser_valid = ($urandom_range(0, 3) != 0);
            ser_sof   = ser_valid && ($urandom_range(0, 47) == 0);
            ser_bit   = 1'($urandom_range(0, 1));
            cw_ready  = ((i / 400) % 2 == 0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0);
            ovf_clr   = ($urandom_range(0, 59) == 0);
            tick();
        end
        ovf_clr = 1'b0;
        idle(2);

        // Async reset mid-frame with one queued codeword.
        cw_ready = 1'b0;
        send_bits(A, N, 0, 0);
        send_bits(C, 7, 0, 0);
        idle(1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {31'b0, cw_valid}, 32'd0);
        chk("arst_data", {3'b0, cw_data}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(1);
        cw_ready = 1'b1; dq.delete();
        send_bits(C, N, 0, 0);
        idle(3);
        chk("arst_count", dq.size(), 32'd1);
        if (dq.size() > 0) chk("arst_data_after", {3'b0, dq[0]}, 32'h15555555);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
